// File: rtl/interp_pkg.sv
// Shared constants and types for the interpolation line sequencer.
// Cycle landmarks are counted from the cycle in which a line start is
// accepted (cycle 0).
package interp_pkg;

    localparam int LINE_LEN   = 16;
    localparam int PAD_L      = 3;
    localparam int PAD_R      = 4;
    localparam int FEED_LEN   = LINE_LEN + PAD_L + PAD_R;

    localparam int ADDR_W     = 8;
    localparam int PIX_W      = 8;
    localparam int ACC_W      = 32;
    localparam int FRAC_SHIFT = 6;
    localparam int OUT_W      = 14;

    localparam int IDX_W      = $clog2(LINE_LEN);

    // Reads happen in cycles 1..FEED_LEN, feed index s = cycle-1.
    localparam int CYC_RD_LAST   = FEED_LEN;
    // Result j needs s = j+PAD_L+PAD_R shifted in (cycle j+9).
    // The filter output is then sampled one cycle later.
    localparam int CYC_CAP_FIRST = PAD_L + PAD_R + 3;
    localparam int CYC_CAP_LAST  = CYC_CAP_FIRST + LINE_LEN - 1;
    // Counter must reach the DONE cycle (last capture + 2).
    localparam int CNT_W         = $clog2(CYC_CAP_LAST + 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/interp_addr_gen.sv
// Pixel address generator for one padded line.
// Maps feed index s to pixel index clamp(s-PAD_L, 0, LINE_LEN-1) and
// forms base + idx*stride, wrapping modulo 2^ADDR_W.
//   seq_i    : feed index s (0..FEED_LEN-1)
//   base_i   : address of pixel 0
//   stride_i : address step between pixels
//   addr_o   : pixel memory address
module interp_addr_gen
    import interp_pkg::*;
(
    input  logic [CNT_W-1:0]  seq_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic [ADDR_W-1:0] addr_o
);

    logic [CNT_W-1:0]  off;
    logic [IDX_W-1:0]  pix_idx;
    logic [ADDR_W-1:0] idx_ext;

    always_comb begin
        off = seq_i - CNT_W'(PAD_L);
        if (seq_i < CNT_W'(PAD_L))
            pix_idx = '0;                       // left edge replication
        else if (off > CNT_W'(LINE_LEN - 1))
            pix_idx = IDX_W'(LINE_LEN - 1);     // right edge replication
        else
            pix_idx = off[IDX_W-1:0];
        idx_ext = ADDR_W'(pix_idx);
        addr_o  = base_i + idx_ext * stride_i;  // truncation gives the wrap
    end

endmodule

// File: rtl/interp_line_sequencer.sv
// Sequences one 16-pixel line through the 8-tap interpolation filter:
// reads the padded pixel stream, gates the filter shift, samples the
// a/b/c accumulators and emits them as 14-bit slices, one per pixel.
//   clock_i, reset_i       : clock, async active-high reset
//   start_i                : line request, sampled only in IDLE
//   base_addr_i, stride_i  : line geometry, latched at acceptance
//   busy_o                 : not IDLE
//   rd_en_o, rd_addr_o     : pixel memory read (data returns next cycle)
//   rd_data_i              : pixel memory read data
//   filt_data_o            : filter shift register input
//   filt_shift_o           : filter shift enable
//   a/b/c_value_i          : filter accumulators
//   out_valid_o, out_idx_o : result strobe and pixel index j
//   out_a/b/c_o            : scaled results (hold when out_valid_o=0)
module interp_line_sequencer
    import interp_pkg::*;
(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic              busy_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [PIX_W-1:0]  rd_data_i,
    output logic [PIX_W-1:0]  filt_data_o,
    output logic              filt_shift_o,
    input  logic [ACC_W-1:0]  a_value_i,
    input  logic [ACC_W-1:0]  b_value_i,
    input  logic [ACC_W-1:0]  c_value_i,
    output logic              out_valid_o,
    output logic [IDX_W-1:0]  out_idx_o,
    output logic [OUT_W-1:0]  out_a_o,
    output logic [OUT_W-1:0]  out_b_o,
    output logic [OUT_W-1:0]  out_c_o
);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;        // cycle number since acceptance
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic              shift_q;             // rd_en delayed to match rd_data
    logic              out_valid_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [OUT_W-1:0]  out_a_q, out_b_q, out_c_q;

    logic              accept;
    logic              cap;
    logic [CNT_W-1:0]  seq;
    logic [CNT_W-1:0]  cap_off;
    logic [ADDR_W-1:0] addr;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(CYC_RD_LAST)) state_d = FLUSH;
            // Leave once the final result is on the outputs.
            FLUSH:   if (out_valid_q && out_idx_q == IDX_W'(LINE_LEN - 1))
                         state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy_o  = (state_q != IDLE);
        rd_en_o = (state_q == RUN);
    end

    // ---------------- datapath ----------------
    assign accept = (state_q == IDLE) && start_i;
    assign seq    = cnt_q - CNT_W'(1);

    always_comb begin
        cnt_d    = cnt_q;
        base_d   = base_q;
        stride_d = stride_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (accept) begin
                cnt_d    = CNT_W'(1);
                base_d   = base_addr_i;
                stride_d = stride_i;
            end
        end else if (state_q == DONE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    interp_addr_gen u_addr_gen (
        .seq_i    (seq),
        .base_i   (base_q),
        .stride_i (stride_q),
        .addr_o   (addr)
    );

    assign rd_addr_o    = rd_en_o ? addr : '0;
    assign filt_shift_o = shift_q;
    assign filt_data_o  = shift_q ? rd_data_i : '0;

    assign cap     = busy_o && (cnt_q >= CNT_W'(CYC_CAP_FIRST))
                            && (cnt_q <= CNT_W'(CYC_CAP_LAST));
    assign cap_off = cnt_q - CNT_W'(CYC_CAP_FIRST);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            shift_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
        end else begin
            cnt_q       <= cnt_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            shift_q     <= rd_en_o;
            out_valid_q <= cap;
            if (cap) begin
                out_idx_q <= cap_off[IDX_W-1:0];
                out_a_q   <= a_value_i[FRAC_SHIFT+OUT_W-1:FRAC_SHIFT];
                out_b_q   <= b_value_i[FRAC_SHIFT+OUT_W-1:FRAC_SHIFT];
                out_c_q   <= c_value_i[FRAC_SHIFT+OUT_W-1:FRAC_SHIFT];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_idx_o   = out_idx_q;
    assign out_a_o     = out_a_q;
    assign out_b_o     = out_b_q;
    assign out_c_o     = out_c_q;

    // Accumulator bits outside the output slice are dropped by design.
    logic unused_bits;
    assign unused_bits = ^{a_value_i[ACC_W-1:FRAC_SHIFT+OUT_W], a_value_i[FRAC_SHIFT-1:0],
                           b_value_i[ACC_W-1:FRAC_SHIFT+OUT_W], b_value_i[FRAC_SHIFT-1:0],
                           c_value_i[ACC_W-1:FRAC_SHIFT+OUT_W], c_value_i[FRAC_SHIFT-1:0],
                           cap_off[CNT_W-1:IDX_W]};

endmodule

// File: doc/interp_line_sequencer.md
Name: interp_line_sequencer

Overview:
- Sequences one 16-pixel line (a row or a column) from pixel memory through the 8-tap interpolation filter datapath.
- Applies edge-replication padding at both ends of the line, gates the filter's shift, and captures the a/b/c quarter/half/three-quarter results.
- Emits the results as scaled 14-bit samples, one per integer pixel position.
- Sits between the frame/line store and the filter; the frame-level scheduler issues one start per line: stride 1 for rows, stride 16 for columns.

Parameters:
- LINE_LEN, 16, pixels per line (N)
- ADDR_W, 8, pixel memory address width
- PIX_W, 8, pixel width
- ACC_W, 32, filter accumulator width (aValue/bValue/cValue)
- FRAC_SHIFT, 6, right shift applied to accumulators
- OUT_W, 14, output sample width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  line request; sampled only in IDLE
- base_addr  in  ADDR_W  address of pixel 0 of the line
- stride  in  ADDR_W  address step between successive pixels
- busy  out  1  high in any state other than IDLE
- rd_en  out  1  pixel memory read strobe
- rd_addr  out  ADDR_W  pixel memory address
- rd_data  in  PIX_W  read data, valid exactly 1 cycle after rd_en
- filt_data  out  PIX_W  sample to filter shift register input
- filt_shift  out  1  filter shift enable; filter holds its buffer when low
- a_value, b_value, c_value  in  ACC_W each  combinational filter outputs
- out_valid  out  1  result strobe
- out_idx  out  $clog2(LINE_LEN)  integer pixel index j of the result
- out_a, out_b, out_c  out  OUT_W each  results, bits [FRAC_SHIFT+OUT_W-1:FRAC_SHIFT] of the accumulators

Behaviour:
- Reset (asynchronous, any time including mid-line):
  - FSM to IDLE; counters cleared.
  - All outputs 0: busy, rd_en, rd_addr, filt_data, filt_shift, out_valid, out_idx, out_a/b/c.
  - The in-flight line is abandoned; no done or partial result afterwards.
- Feed sequence: s = 0..N+6 (23 values). Value s is pixel clamp(s-3, 0, N-1), giving 3 left pads and 4 right pads.
- rd_addr = base_addr + clamp(s-3,0,N-1)*stride, truncated mod 2^ADDR_W (wraps silently).
- FSM states IDLE -> RUN -> FLUSH -> DONE -> IDLE. Cycle 0 is the cycle in which start is sampled high in IDLE.
  - RUN, cycles 1..23: rd_en=1 with address for s = cycle-1. Leaves RUN after s=N+6.
  - Feed timing: in cycle s+2, filt_data = rd_data (registered pass) and filt_shift=1. filt_shift is high in exactly cycles 2..24 and low otherwise.
  - FLUSH: waits until the last result has been emitted.
  - DONE: one cycle, busy still 1, out_valid 0. Then IDLE; a new start is accepted the following cycle.
- Result capture:
  - After shift of s=j+7, the filter buffer holds p(j-3)..p(j+4); a/b/c are sampled in cycle j+10.
  - Registered results: out_valid=1 in cycles j+11, i.e. cycles 11..26 for N=16, with out_idx=j.
  - out_valid is low in all other cycles; out_a/b/c hold their last values when out_valid=0.
- Latency: first result at cycle 11; line complete (DONE) at cycle 27; next start earliest cycle 28.
- Arithmetic: plain bit slice, no rounding, no saturation. Negative accumulators yield the two's-complement slice, e.g. -2805 -> 16340.
- start while busy: ignored, no queuing. base_addr/stride are latched at acceptance; later changes have no effect on the current line.
- rd_data is ignored except in cycles 2..24.

Decomposition:
- Package interp_pkg:
  - LINE_LEN, PAD_L=3, PAD_R=4, FEED_LEN=LINE_LEN+PAD_L+PAD_R, FRAC_SHIFT, OUT_W
  - state enum seq_state_t {IDLE, RUN, FLUSH, DONE}
- One sub-module, interp_addr_gen: combinational clamp(s-3) and base+idx*stride address computation, reused later by the 2-D frame scheduler.

Test Plan:
- Constant line, all pixels 100, base 0, stride 1 -> out_a=out_b=out_c=100 for j=0..15; out_valid exactly cycles 11..26; busy cycles 1..27.
- Ramp row 0,8,17,25,34,... (base 0, stride 1) -> j=0 out_b=3 (acc 199); rd_addr sequence 0,0,0,0,1,2,...,15,15,15,15,15.
- Column mode, base 3, stride 16 -> rd_addr: 3 for s=0..3, then 19,35,...,243, then 243 for s=18..22; 23 reads total in cycles 1..23.
- Impulse line, p5=255, others 0 -> j=3 out_b=16340 (acc -2805) and j=4 out_a=58*255>>6=231.
- start pulsed at cycles 5 and 27 -> both ignored; start at cycle 28 accepted with rd_en at cycle 29.
- reset asserted at cycle 15 mid-line -> all outputs 0 immediately; no out_valid or DONE afterwards; next start after release behaves as a fresh line.
